// File: rtl/codes.sv
// Shared encodings and helpers for the memory bus master.
package codes;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } mem_port_state_t;

  // Move right-justified store data onto the byte lanes selected by the address offset.
  function automatic logic [DATA_W-1:0] steer_store_data(input logic [DATA_W-1:0] data,
                                                         input logic [1:0] offset);
    return data << {offset, 3'b000};
  endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Watchdog for stalled bus transactions: counts consecutive stalled WAIT cycles
// and raises a sticky error when the limit is reached.
module mem_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  output logic timeout_c,
  output logic bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign timeout_c = count_en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Consecutive-stall counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      bus_error <= 1'b0;
    end else begin
      if (!count_en || timeout_c) count <= '0;
      else                        count <= count + CNT_W'(1);
      if (timeout_c) bus_error <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// Avalon-MM master port for the multicycle CPU. Requests issue with zero added
// latency and are held in registers across waitrequest.
// Optional feature: define MEM_TIMEOUT_EN to enable the waitrequest watchdog.
module mem_bus_master
  import codes::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ram_read_en_i,
  input  logic        ram_write_en_i,
  input  logic [3:0]  ram_byte_en_i,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_wr_data_i,
  output logic        stall_o,
  output logic        readdata_valid_o,
  output logic [31:0] readdata_o,
  output logic        bus_error_o,
  output logic [31:0] avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [3:0]  avm_byteenable_o,
  output logic [31:0] avm_writedata_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i
);

  mem_port_state_t state, state_next;

  logic [31:0] hold_addr, hold_data, rd_hold;
  logic [3:0]  hold_be;
  logic        hold_write;

  logic        req_write, req_read, req_active;
  logic        latch_req, stalled_wait, timeout;
  logic [31:0] req_addr, req_data;

  // A simultaneous read and write request keeps only the write.
  assign req_write    = ram_write_en_i;
  assign req_read     = ram_read_en_i & ~ram_write_en_i;
  assign req_active   = req_write | req_read;
  assign req_addr     = {ram_addr_i[31:2], 2'b00};
  assign req_data     = steer_store_data(ram_wr_data_i, ram_addr_i[1:0]);
  assign stalled_wait = (state == WAIT) && avm_waitrequest_i;

`ifdef MEM_TIMEOUT_EN
  mem_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .count_en  (stalled_wait),
    .timeout_c (timeout),
    .bus_error (bus_error_o)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (|TIMEOUT_CYCLES) & stalled_wait;
  assign timeout            = 1'b0;
  assign bus_error_o        = 1'b0;
`endif

  // Next-state and bus outputs: live request when issue-capable, hold registers in WAIT.
  always_comb begin
    state_next       = state;
    latch_req        = 1'b0;
    avm_address_o    = req_addr;
    avm_byteenable_o = ram_byte_en_i;
    avm_writedata_o  = req_data;
    avm_read_o       = 1'b0;
    avm_write_o      = 1'b0;
    stall_o          = 1'b0;
    readdata_valid_o = 1'b0;
    readdata_o       = rd_hold;

    case (state)
      WAIT: begin
        avm_address_o    = hold_addr;
        avm_byteenable_o = hold_be;
        avm_writedata_o  = hold_data;
        avm_read_o       = ~hold_write;
        avm_write_o      = hold_write;
        stall_o          = avm_waitrequest_i;
        if (!avm_waitrequest_i) state_next = hold_write ? IDLE : DATA;
        else if (timeout)       state_next = IDLE;
      end
      IDLE, DATA: begin
        if (state == DATA) begin
          readdata_valid_o = 1'b1;
          readdata_o       = avm_readdata_i;
        end
        avm_read_o  = req_read;
        avm_write_o = req_write;
        stall_o     = req_active & avm_waitrequest_i;
        if (!req_active) begin
          state_next = IDLE;
        end else if (avm_waitrequest_i) begin
          latch_req  = 1'b1;
          state_next = WAIT;
        end else begin
          state_next = req_read ? DATA : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (reset) begin
      avm_read_o       = 1'b0;
      avm_write_o      = 1'b0;
      stall_o          = 1'b0;
      readdata_valid_o = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request hold registers and last-read-word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_addr  <= '0;
      hold_data  <= '0;
      hold_be    <= '0;
      hold_write <= 1'b0;
      rd_hold    <= '0;
    end else begin
      if (latch_req) begin
        hold_addr  <= req_addr;
        hold_data  <= req_data;
        hold_be    <= ram_byte_en_i;
        hold_write <= req_write;
      end
      if (state == DATA) rd_hold <= avm_readdata_i;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed scenarios then random traffic,
// all compared against a transaction-level model of the port.
module tb_mem_bus_master;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        rd, wr_en;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        waitreq;
  logic [31:0] rdata;

  logic        stall, valid, bus_error, avm_read, avm_write;
  logic [31:0] readdata, avm_address, avm_writedata;
  logic [3:0]  avm_be;

  int checks   = 0;
  int failures = 0;

  // Model: at most one outstanding transaction plus a pending read-return slot.
  logic        m_busy, m_wr, m_vdue, m_err;
  logic [31:0] m_addr, m_data, m_last;
  logic [3:0]  m_be;
  int          m_wcnt;

  logic        e_rd, e_wr, e_stall, e_valid;
  logic [31:0] e_addr, e_data, e_rdata;
  logic [3:0]  e_be;

  mem_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .reset             (rst),
    .ram_read_en_i     (rd),
    .ram_write_en_i    (wr_en),
    .ram_byte_en_i     (be),
    .ram_addr_i        (addr),
    .ram_wr_data_i     (wdata),
    .stall_o           (stall),
    .readdata_valid_o  (valid),
    .readdata_o        (readdata),
    .bus_error_o       (bus_error),
    .avm_address_o     (avm_address),
    .avm_read_o        (avm_read),
    .avm_write_o       (avm_write),
    .avm_byteenable_o  (avm_be),
    .avm_writedata_o   (avm_writedata),
    .avm_waitrequest_i (waitreq),
    .avm_readdata_i    (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_wr = 1'b0; m_vdue = 1'b0; m_err = 1'b0;
    m_addr = '0; m_data = '0; m_last = '0; m_be = '0; m_wcnt = 0;
  endtask

  // Mid-cycle: predict outputs from the model and current inputs, then compare.
  task automatic eval();
    @(negedge clk);
    e_valid = m_vdue && !rst;
    e_rdata = m_vdue ? rdata : m_last;
    if (m_busy) begin
      e_rd = !m_wr; e_wr = m_wr; e_addr = m_addr; e_be = m_be; e_data = m_data;
      e_stall = waitreq;
    end else begin
      e_wr    = wr_en;
      e_rd    = rd && !wr_en;
      e_addr  = addr & ~32'h3;
      e_be    = be;
      e_data  = wdata << (8 * int'(addr[1:0]));
      e_stall = (e_rd || e_wr) && waitreq;
    end
    if (rst) begin
      e_rd = 1'b0; e_wr = 1'b0; e_stall = 1'b0; e_valid = 1'b0;
    end
    chk1("read", avm_read, e_rd);
    chk1("write", avm_write, e_wr);
    chk1("stall", stall, e_stall);
    chk1("valid", valid, e_valid);
    chk1("bus_error", bus_error, m_err);
    if (e_rd || e_wr) begin
      chk("address", avm_address, e_addr);
      chk("byteenable", 32'(avm_be), 32'(e_be));
    end
    if (e_wr) chk("writedata", avm_writedata, e_data);
    if (!rst) chk("readdata", readdata, e_rdata);
  endtask

  // Clock edge: advance the model, then move just past the edge.
  task automatic commit();
    if (rst) begin
      model_reset();
    end else begin
      if (m_vdue) m_last = rdata;
      m_vdue = 1'b0;
      if (m_busy) begin
        if (!waitreq) begin
          m_busy = 1'b0;
          m_wcnt = 0;
          if (!m_wr) m_vdue = 1'b1;
        end else begin
`ifdef MEM_TIMEOUT_EN
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_busy = 1'b0; m_err = 1'b1; m_wcnt = 0;
          end
`endif
        end
      end else if (e_rd || e_wr) begin
        if (!waitreq) begin
          m_vdue = e_rd;
        end else begin
          m_busy = 1'b1; m_wr = e_wr; m_addr = e_addr; m_be = e_be; m_data = e_data;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    eval();
    commit();
  endtask

  task automatic idle_in();
    rd = 1'b0; wr_en = 1'b0; be = 4'h0; addr = $urandom; wdata = $urandom;
    waitreq = 1'b0; rdata = $urandom;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Reset state
    eval();
    chk("reset_readdata", readdata, 32'h0);
    chk1("reset_bus_error", bus_error, 1'b0);
    commit();

    // Read with no wait, data returned next cycle and held after
    rd = 1'b1; addr = 32'h0000_1004; be = 4'hF;
    eval();
    chk1("rd_strobe", avm_read, 1'b1);
    chk("rd_addr", avm_address, 32'h0000_1004);
    commit();
    idle_in(); rdata = 32'hDEAD_BEEF;
    eval();
    chk1("rd_valid", valid, 1'b1);
    chk("rd_data", readdata, 32'hDEAD_BEEF);
    commit();
    idle_in();
    eval();
    chk1("rd_valid_drop", valid, 1'b0);
    chk("rd_hold", readdata, 32'hDEAD_BEEF);
    commit();

    // Store byte at offset 3
    wr_en = 1'b1; addr = 32'h0000_2003; wdata = 32'h0000_00AB; be = 4'b1000;
    eval();
    chk("sb_addr", avm_address, 32'h0000_2000);
    chk("sb_wdata", avm_writedata, 32'hAB00_0000);
    chk1("sb_stall", stall, 1'b0);
    commit();

    // Read held by waitrequest for 3 cycles while upstream address changes
    idle_in(); rd = 1'b1; addr = 32'h0000_3000; be = 4'hF; waitreq = 1'b1;
    eval();
    chk1("wait_stall0", stall, 1'b1);
    commit();
    for (int i = 0; i < 2; i++) begin
      addr = 32'h0000_5554 + 32'(i);
      eval();
      chk1("wait_stall", stall, 1'b1);
      chk("wait_addr", avm_address, 32'h0000_3000);
      commit();
    end
    waitreq = 1'b0;
    eval();
    chk1("wait_release_stall", stall, 1'b0);
    chk("wait_release_addr", avm_address, 32'h0000_3000);
    commit();

    // Back-to-back: write issued in the DATA cycle of the released read
    idle_in(); wr_en = 1'b1; addr = 32'h0000_4000; wdata = 32'h1234_5678; be = 4'hF;
    rdata = 32'hCAFE_F00D;
    eval();
    chk1("b2b_valid", valid, 1'b1);
    chk1("b2b_write", avm_write, 1'b1);
    chk("b2b_data", readdata, 32'hCAFE_F00D);
    commit();

    // Reset in WAIT abandons the read
    idle_in(); rd = 1'b1; addr = 32'h0000_6000; be = 4'hF; waitreq = 1'b1;
    step();
    rst = 1'b1; rd = 1'b0;
    eval();
    chk1("rst_wait_read", avm_read, 1'b0);
    commit();
    rst = 1'b0; idle_in();
    eval();
    chk1("rst_wait_valid", valid, 1'b0);
    chk1("rst_wait_idle", avm_read, 1'b0);
    commit();
    step();

`ifdef MEM_TIMEOUT_EN
    // Waitrequest stuck high trips the watchdog
    idle_in(); rd = 1'b1; addr = 32'h0000_7000; be = 4'hF; waitreq = 1'b1;
    step();
    rd = 1'b0;
    for (int i = 0; i < TO; i++) step();
    eval();
    chk1("wd_error", bus_error, 1'b1);
    chk1("wd_stall", stall, 1'b0);
    chk1("wd_read", avm_read, 1'b0);
    commit();
    step();
    rst = 1'b1; step(); rst = 1'b0;
    eval();
    chk1("wd_error_clr", bus_error, 1'b0);
    commit();
`endif

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r       = int'($urandom_range(0, 9));
      rst     = ($urandom_range(0, 59) == 0);
      rd      = (r < 4) || (r == 9);
      wr_en   = (r >= 4 && r < 7) || (r == 9);
      be      = 4'($urandom);
      addr    = $urandom;
      wdata   = $urandom;
      waitreq = ($urandom_range(0, 9) < 4);
      rdata   = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
